serial_nib_cmp: RTL

- Sequential magnitude comparator for two WIDTH-bit words.
- Compares one 4-bit nibble per clock, most significant nibble first.
- Carries a gt/lt/eq cascade state between nibbles, in the same way a 7485-style comparator chain passes cascade state from one stage to the next.
- Accepts operand pairs over a valid/ready handshake and returns gt/lt/eq over a second valid/ready handshake.
- Used where a parallel comparator tree is too large, and as a cycle-accurate cross-check on the combinational comparators.

---
 rtl/serial_nib_cmp.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/serial_nib_cmp.sv
// -----------------------------------------------------------------------------
// serial_nib_cmp
//
// Sequential unsigned magnitude comparator. One 4-bit nibble of each operand
// is compared per clock, most significant nibble first. The gt/lt decision is
// carried from nibble to nibble like a 7485 cascade chain. When every nibble
// is equal, the registered cascade inputs (ieq/iegf/ielf) decide the result.
// Latency is fixed at NNIB+1 cycles, with no early exit.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   in_valid   operand pair present            (input handshake)
//   in_ready   block can accept an operand pair
//   e, f       operands A and B, WIDTH bits, unsigned
//   ieq/iegf/ielf  cascade inputs, sampled together with the operands
//   out_valid  result valid                    (output handshake)
//   out_ready  downstream accepts the result
//   oegf/oelf/oeq  result e>f / e<f / e==f, held until the next result
// -----------------------------------------------------------------------------
module serial_nib_cmp #(
    parameter int WIDTH = 8,          // multiple of 4, at least 4
    parameter int NNIB  = WIDTH / 4   // derived, do not override
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic             ieq,
    input  logic             iegf,
    input  logic             ielf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             oegf,
    output logic             oelf,
    output logic             oeq
);

    localparam int CW = (NNIB > 1) ? $clog2(NNIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  e_q, f_q;
    logic              ieq_q, iegf_q, ielf_q;
    logic [CW-1:0]     cnt_q;
    logic              decided_q, gt_q, lt_q;
    logic              in_ready_q, out_valid_q;
    logic              oegf_q, oelf_q, oeq_q;

    // Nibble selection and the decision including the current nibble.
    logic [CW-1:0]     nib_idx;
    logic [CW+1:0]     nib_shift;
    logic [WIDTH-1:0]  e_sh, f_sh;
    logic [3:0]        e_nib, f_nib;
    logic              dec_now, gt_now, lt_now, last_nib;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        nib_idx   = CW'(NNIB - 1) - cnt_q;
        nib_shift = {nib_idx, 2'b00};
        e_sh      = e_q >> nib_shift;
        f_sh      = f_q >> nib_shift;
        e_nib     = e_sh[3:0];
        f_nib     = f_sh[3:0];
        last_nib  = (cnt_q == CW'(NNIB - 1));
        dec_now   = decided_q || (e_nib != f_nib);
        // Once decided, later nibbles cannot change the verdict.
        gt_now    = decided_q ? gt_q : (e_nib > f_nib);
        lt_now    = decided_q ? lt_q : (e_nib < f_nib);
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // takes effect only on a rising edge; the operand copies are cleared too,
    // which keeps the post-reset state fully deterministic.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            e_q         <= '0;
            f_q         <= '0;
            ieq_q       <= 1'b0;
            iegf_q      <= 1'b0;
            ielf_q      <= 1'b0;
            cnt_q       <= '0;
            decided_q   <= 1'b0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            oegf_q      <= 1'b0;
            oelf_q      <= 1'b0;
            oeq_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        e_q        <= e;
                        f_q        <= f;
                        ieq_q      <= ieq;
                        iegf_q     <= iegf;
                        ielf_q     <= ielf;
                        cnt_q      <= '0;
                        decided_q  <= 1'b0;
                        gt_q       <= 1'b0;
                        lt_q       <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= CMP;
                    end
                end
                CMP: begin
                    decided_q <= dec_now;
                    gt_q      <= gt_now;
                    lt_q      <= lt_now;
                    cnt_q     <= cnt_q + CW'(1);
                    if (last_nib) begin
                        cnt_q       <= '0;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        if (dec_now) begin
                            oegf_q <= gt_now;
                            oelf_q <= lt_now;
                            oeq_q  <= 1'b0;
                        end else if (ieq_q) begin
                            // 7485 priority: cascade-equal wins.
                            oegf_q <= 1'b0;
                            oelf_q <= 1'b0;
                            oeq_q  <= 1'b1;
                        end else begin
                            // iegf=ielf=1 passes through as both set.
                            oegf_q <= iegf_q;
                            oelf_q <= ielf_q;
                            oeq_q  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    // No bypass: IDLE is entered first, then a new pair.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign oegf      = oegf_q;
    assign oelf      = oelf_q;
    assign oeq       = oeq_q;

endmodule
